// File: rtl/csla_bec_group_reg.sv
// One carry-select adder group using an RCA plus binary-to-excess-1 converter, with registered sum/cout.
// Optional input register stage enabled by defining CSLA_IN_REG_EN (latency 2 instead of 1).
module csla_bec_group_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] a_stage;
   logic [WIDTH-1:0] b_stage;
   logic             cin_stage;
   logic             valid_stage;

`ifdef CSLA_IN_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_stage     <= '0;
         b_stage     <= '0;
         cin_stage   <= 1'b0;
         valid_stage <= 1'b0;
      end else begin
         a_stage     <= a;
         b_stage     <= b;
         cin_stage   <= cin;
         valid_stage <= in_valid;
      end
   end
`else
   assign a_stage     = a;
   assign b_stage     = b;
   assign cin_stage   = cin;
   assign valid_stage = in_valid;
`endif

   logic [WIDTH-1:0] sum_rca;
   logic [WIDTH:0]   carry;
   logic             cout_rca;
   logic [WIDTH-1:0] sum_bec;
   logic [WIDTH:0]   and_chain;
   logic             cout_bec;

   // Ripple-carry adder with carry-in tied low; cin never enters the adder.
   always_comb begin
      carry    = '0;
      sum_rca  = '0;
      carry[0] = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         sum_rca[i]   = a_stage[i] ^ b_stage[i] ^ carry[i];
         carry[i + 1] = (a_stage[i] & b_stage[i]) | (carry[i] & (a_stage[i] ^ b_stage[i]));
      end
      cout_rca = carry[WIDTH];
   end

   // Excess-1: bit i flips when all lower bits are one.
   always_comb begin
      and_chain    = '0;
      sum_bec      = '0;
      and_chain[0] = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         sum_bec[i]       = sum_rca[i] ^ and_chain[i];
         and_chain[i + 1] = and_chain[i] & sum_rca[i];
      end
      cout_bec = cout_rca ^ and_chain[WIDTH];
   end

   logic [WIDTH-1:0] sum_mux;
   logic             cout_mux;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_mux
         assign sum_mux[gi] = cin_stage ? sum_bec[gi] : sum_rca[gi];
      end
   endgenerate
   assign cout_mux = cin_stage ? cout_bec : cout_rca;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= valid_stage;
         if (valid_stage) begin
            sum  <= sum_mux;
            cout <= cout_mux;
         end
      end
   end

endmodule

// File: tb/tb_csla_bec_group_reg.sv
// Directed and exhaustive checks of csla_bec_group_reg (WIDTH=4); latency follows CSLA_IN_REG_EN.
module tb_csla_bec_group_reg;

   localparam int WIDTH = 4;
`ifdef CSLA_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int tests  = 0;
   int failed = 0;

   logic [WIDTH:0] exp_q[$];

   csla_bec_group_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic c);
      @(negedge clk);
      in_valid = v;
      a        = av;
      b        = bv;
      cin      = c;
   endtask

   task automatic result(input string tag, input logic v, input logic [WIDTH-1:0] s, input logic c);
      repeat (LAT) @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_sum"}, 32'(sum), 32'(s));
      chk({tag, "_cout"}, 32'(cout), 32'(c));
      $display("[TB] %s: a=%0h b=%0h cin=%0b -> valid=%0b sum=%0h cout=%0b",
               tag, a, b, cin, out_valid, sum, cout);
   endtask

   initial begin
      logic [WIDTH:0] e;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_sum", 32'(sum), 32'd0);
      chk("reset_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;

      drive(1'b1, 4'h6, 4'h1, 1'b0); result("6+1+0", 1'b1, 4'h7, 1'b0);
      drive(1'b1, 4'h9, 4'h1, 1'b0); result("9+1+0", 1'b1, 4'hA, 1'b0);
      drive(1'b1, 4'h9, 4'h1, 1'b1); result("9+1+1", 1'b1, 4'hB, 1'b0);
      drive(1'b1, 4'h9, 4'hF, 1'b1); result("9+F+1", 1'b1, 4'h9, 1'b1);
      drive(1'b1, 4'hF, 4'hF, 1'b1); result("F+F+1", 1'b1, 4'hF, 1'b1);
      drive(1'b1, 4'hF, 4'hF, 1'b0); result("F+F+0", 1'b1, 4'hE, 1'b1);

      // Valid drop: result of 3+4 must be held while invalid operands are presented.
      drive(1'b1, 4'h3, 4'h4, 1'b0);
      drive(1'b0, 4'hF, 4'hF, 1'b1);
      result("hold", 1'b0, 4'h7, 1'b0);

      // Asynchronous reset pulse between edges.
      drive(1'b1, 4'hF, 4'hF, 1'b0); result("pre_rst", 1'b1, 4'hE, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_sum", 32'(sum), 32'd0);
      chk("async_rst_cout", 32'(cout), 32'd0);
      $display("[TB] async reset: valid=%0b sum=%0h cout=%0b", out_valid, sum, cout);
      #1 rst_n = 1'b1;
      drive(1'b1, 4'h1, 4'h2, 1'b1); result("post_rst", 1'b1, 4'h4, 1'b0);

      // Exhaustive pipelined sweep, one new operand set every cycle.
      exp_q.delete();
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            chk("sweep_valid", 32'(out_valid), 32'd1);
            chk("sweep_result", 32'({cout, sum}), 32'(e));
         end
         in_valid = 1'b1;
         a        = WIDTH'(i[7:4]);
         b        = WIDTH'(i[3:0]);
         cin      = i[8];
         exp_q.push_back((WIDTH + 1)'(i[7:4]) + (WIDTH + 1)'(i[3:0]) + (WIDTH + 1)'(i[8]));
      end
      repeat (LAT) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk("sweep_valid", 32'(out_valid), 32'd1);
         chk("sweep_result", 32'({cout, sum}), 32'(e));
      end
      $display("[TB] sweep: 512 combinations checked");
      in_valid = 1'b0;
      repeat (LAT) @(negedge clk);
      chk("final_valid", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/csla_bec_group_reg.md
Name: csla_bec_group_reg

Overview:
- One group of a carry-select adder (CSLA) that uses a binary-to-excess-1 converter (BEC) instead of a second ripple adder, with registered outputs.
- Ripple-carry adder (rca4_1 style) computes a+b with carry-in 0; BEC (bec4 style) derives the +1 result; a 2:1 mux bank (mux_21 style) selects on cin.
- Cascaded by higher-level 32-bit CSLA/Karatsuba datapaths, one instance per WIDTH-bit slice.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b/cin valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  group carry-in; also the select for the result muxes
- out_valid  output  1  sum/cout hold a fresh result
- sum  output  WIDTH  registered (a+b+cin) mod 2^WIDTH
- cout  output  1  registered carry-out of a+b+cin

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Datapath, combinational:
  - RCA: a chain of WIDTH full adders, carry-in tied to 0, producing sum_rca[WIDTH-1:0] and cout_rca.
  - BEC: {cout_bec,sum_bec} = {cout_rca,sum_rca} + 1. Implemented with the XOR/AND-chain structure: bit0 inverted; bit i is XORed with the AND of bits 0..i-1; cout_bec is cout_rca XOR the AND of all sum_rca bits.
  - Mux bank: WIDTH+1 two-input muxes, with sel=cin. cin=0 selects the RCA path and cin=1 selects the BEC path.
- No adder may use the cin input directly. cin only drives the mux selects.
- {cout,sum} must equal a+b+cin exactly for every input combination. The BEC never overflows because a+b ≤ 2^(WIDTH+1)-2.
- Register stage:
  - On a rising clk with in_valid=1: sum and cout load the mux outputs, and out_valid goes to 1.
  - On a rising clk with in_valid=0: sum and cout hold their previous values, and out_valid goes to 0.
- Latency: 1 cycle from in_valid sampled high to out_valid high with the matching result. Throughput is 1 result per cycle; there is no backpressure.
- Reset: asserting rst_n=0 immediately forces sum=0, cout=0 and out_valid=0, regardless of clk. This applies mid-operation too: any result in flight is discarded.
- Release: the first capture happens on the first rising clk after rst_n rises with in_valid=1.
- X/Z on inputs while in_valid=0 must not affect the outputs.

Optional Feature:
- Macro CSLA_IN_REG_EN.
- Defined: adds an input register stage on a, b, cin and in_valid, reset to 0 by the same async rst_n. Latency becomes 2 cycles, and out_valid follows in_valid delayed by 2. The hold rule applies at the output stage, keyed on the registered in_valid.
- Undefined: no input registers; latency is 1 cycle as specified above.
- Arithmetic results are identical in both builds.

Test Plan:
- WIDTH=4, a=6, b=1, cin=0, in_valid=1 -> one cycle later out_valid=1, sum=7, cout=0.
- a=9, b=1: with cin=0 -> sum=0xA, cout=0; with cin=1 -> sum=0xB, cout=0 (BEC path selected).
- a=9, b=0xF, cin=1 -> sum=9, cout=1. Then a=0xF, b=0xF, cin=1 -> sum=0xF, cout=1. Then cin=0 -> sum=0xE, cout=1.
- Drive in_valid=1 with a=3, b=4, then in_valid=0 with a=0xF, b=0xF -> out_valid drops to 0, and sum=7, cout=0 are held.
- Pulse rst_n low between clock edges while out_valid=1, sum=0xE -> sum, cout and out_valid go to 0 before the next edge. After release, a=1, b=2, cin=1 -> sum=4.
- Exhaustive sweep of all 512 (a,b,cin) combinations with in_valid=1 -> {cout,sum}=a+b+cin every cycle. Repeat with CSLA_IN_REG_EN defined and check 2-cycle latency.
